// File: rtl/fifo_pkg.sv
// Shared sizing helpers, output-stage state type and parameter legality check
// for the first-word-fall-through FIFO.
package fifo_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Room for depth+1 words: RAM plus the output register.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit params_legal(input int addr_width, input int data_width,
                                        input int almost_full_num, input int almost_empty_num);
        return (addr_width >= 4) && (addr_width <= 10) &&
               (data_width >= 1) && (data_width <= 256) &&
               (almost_full_num >= 1) && (almost_full_num <= fifo_depth(addr_width)) &&
               (almost_empty_num >= 0) && (almost_empty_num <= fifo_depth(addr_width));
    endfunction

endpackage

// File: rtl/dist_sdpram_core.sv
// Distributed simple-dual-port RAM: registered write, combinational read.
// Latency: write visible one edge later; read is same-cycle.
// Backpressure: none; the caller guarantees we only on free slots.
module dist_sdpram_core
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft_ctrl.sv
// Single-clock FWFT FIFO: distributed RAM plus one registered output word.
// Latency: a word written at one edge shows on rd_data after the next edge.
// Backpressure: rd_valid/rd_ready on the output; writes while full are dropped and flagged by overflow.
module sync_fifo_fwft_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_NUM  = 12,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int                LW      = level_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = LW'(fifo_depth(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] AF_C    = LW'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_C    = LW'(ALMOST_EMPTY_NUM);

    if (!params_legal(ADDR_WIDTH, DATA_WIDTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_param_check
        $error("sync_fifo_fwft_ctrl: parameter outside legal range");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [DATA_WIDTH-1:0] ram_rdata;
    out_state_t            out_state;
    logic                  wr_acc;
    logic                  ld;

    assign wr_acc = wr_en & ~full;
    assign ld     = (ram_cnt != '0) & (~rd_valid | rd_ready);

    dist_sdpram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            rd_data   <= '0;
            out_state <= OUT_EMPTY;
            overflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (out_state)
                OUT_EMPTY: begin
                    if (ld) begin
                        rd_data   <= ram_rdata;
                        rd_ptr    <= rd_ptr + 1'b1;
                        out_state <= OUT_VALID;
                    end
                end
                OUT_VALID: begin
                    if (ld) begin
                        rd_data <= ram_rdata;
                        rd_ptr  <= rd_ptr + 1'b1;
                    end else if (rd_ready) begin
                        out_state <= OUT_EMPTY;
                    end
                end
                default: out_state <= OUT_EMPTY;
            endcase
            ram_cnt  <= ram_cnt + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, ld};
            overflow <= wr_en & full;
        end
    end

    // Status is decoded from registered state only, so no input reaches these outputs.
    assign rd_valid     = (out_state == OUT_VALID);
    assign full         = (ram_cnt == DEPTH_C);
    assign level        = ram_cnt + {{ADDR_WIDTH{1'b0}}, rd_valid};
    assign almost_full  = (level >= AF_C);
    assign almost_empty = (level <= AE_C);

endmodule

// File: doc/sync_fifo_fwft_ctrl.md
Name: sync_fifo_fwft_ctrl

Overview:
Single-clock first-word-fall-through FIFO built on an internal distributed simple-dual-port RAM (combinational read).
- Owns the write/read pointers and occupancy counting.
- Drives a one-word output register with a valid/ready handshake, so consumers (FFT/FIR sample paths) read the RAM directly without latency bookkeeping.
- Total capacity is 2**ADDR_WIDTH words in RAM plus 1 word in the output register.

Parameters:
ADDR_WIDTH, 4, RAM address width, legal range 4-10; RAM depth = 2**ADDR_WIDTH.
DATA_WIDTH, 16, word width, legal range 1-256.
ALMOST_FULL_NUM, 12, almost_full threshold on level; legal range 1 to 2**ADDR_WIDTH.
ALMOST_EMPTY_NUM, 2, almost_empty threshold on level; legal range 0 to 2**ADDR_WIDTH.

Ports:
clk  input  1  sole clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  write word.
full  output  1  RAM holds 2**ADDR_WIDTH words; writes are rejected.
almost_full  output  1  level >= ALMOST_FULL_NUM.
overflow  output  1  one-cycle pulse on a rejected write.
rd_valid  output  1  rd_data holds the oldest word.
rd_ready  input  1  consumer accepts rd_data when rd_valid is high.
rd_data  output  DATA_WIDTH  output word (registered).
almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
level  output  ADDR_WIDTH+1  total words held = ram_cnt + rd_valid.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wr_ptr, rd_ptr, ram_cnt, rd_data, rd_valid, level, full, almost_full and overflow all go to 0.
  - almost_empty goes to 1.
  - RAM contents are not reset.
  - Reset mid-operation discards all buffered words; the first write after release is the first word read.
- Write accept: wr_acc = wr_en & ~full.
  - On accept, mem[wr_ptr] <= wr_data and wr_ptr increments, wrapping modulo 2**ADDR_WIDTH.
  - wr_en & full: RAM, pointers and counters are unchanged; overflow = 1 on the next cycle only.
- Output load: ld = (ram_cnt != 0) & (~rd_valid | rd_ready).
  - On ld, rd_data <= mem[rd_ptr], rd_ptr increments (wrapping), rd_valid <= 1.
  - rd_valid & rd_ready & ram_cnt == 0: rd_valid <= 0.
  - rd_valid & ~rd_ready: rd_data and rd_valid hold, bit-stable.
- Counter update: ram_cnt <= ram_cnt + wr_acc - ld. It is ADDR_WIDTH+1 bits wide and can never over- or underflow.
- Status flags:
  - full = (ram_cnt == 2**ADDR_WIDTH).
  - level, almost_full and almost_empty are derived from registered counts only; no combinational path from wr_en or rd_ready.
- Latency:
  - A word written at edge E0 is first visible with rd_valid = 1 after edge E1.
  - There is no write-to-output bypass.
  - Sustained throughput is 1 word/cycle in and 1 word/cycle out.
- Simultaneous events:
  - Write and load in the same cycle are both performed; ram_cnt is unchanged.
  - Write while full and rd_ready in the same cycle: the write is still rejected. full is sampled from the current ram_cnt; no same-cycle pass-through.
- Output-stage states:
  - EMPTY (rd_valid = 0) goes to VALID on ld.
  - VALID stays VALID on ld, or when ~rd_ready.
  - VALID goes to EMPTY when rd_ready & ram_cnt == 0.
- Pointer wrap is natural binary; there is no extra wrap bit because occupancy comes from ram_cnt.

Decomposition:
- Shared package (fifo_pkg) holds:
  - the function for depth = 2**ADDR_WIDTH;
  - the level width ADDR_WIDTH+1;
  - the legal-range parameter checks (elaboration-time assertions).
- One sub-module, dist_sdpram_core: single-clock write, combinational read, no reset, mem array only.
- Pointers, counters, flags and the output stage stay in sync_fifo_fwft_ctrl.

Test Plan:
All scenarios use ADDR_WIDTH=4, DATA_WIDTH=16 and defaults unless stated.
- Reset, then write 0xA5A5 at edge 0 with rd_ready=0 -> rd_valid=1 and rd_data=0xA5A5 after edge 1; level=1; almost_empty=1; full=0.
- rd_ready=0, write values 0..17 on consecutive cycles -> 0..16 are accepted; level=17; full=1; almost_full=1 from level 12; value 17 gives a single overflow pulse and level stays 17.
- From the previous state, hold rd_ready=1 -> 0..16 emerge on 17 consecutive cycles with no bubbles; then rd_valid=0, level=0, full drops after the first read.
- Steady state at level 8: write and read every cycle for 40 words -> level stays 8; order is preserved across pointer wrap; overflow stays 0.
- Random wr_en and rd_ready (seeded, 2000 cycles) -> scoreboard matches; rd_data is stable while rd_valid & ~rd_ready; overflow occurs only when wr_en & full.
- At level 10, pulse rst_n low asynchronously between edges -> rd_valid, level and full are 0 immediately; after release, write 0x1234 -> the first read word is 0x1234.
